// File: rtl/reg_bank_ctl.sv
// -----------------------------------------------------------------------------
// reg_bank_ctl
//   CPU register bank for the MAC host interface. It holds NREG registers of
//   DW bits. Each register has its own reset value, and a register can be made
//   self-clearing. The bank also contains an indirect RMON counter read engine
//   that sits behind a three-index window.
//
//   Bus accesses are edge-qualified. An access commits once, on the first
//   Clk_reg edge at which CSB is sampled low after having been high. Ack pulses
//   for one cycle after each commit.
//
//   Counter window (indices WIN_IDX .. WIN_IDX+2):
//     WIN_IDX   write: command, with the counter address in CD_in[CNT_AW-1:0]
//               read : status {0.., ovr, tmo, done, busy}; a read clears ovr
//     WIN_IDX+1 read : shadow[DW-1:0]
//     WIN_IDX+2 read : shadow[2*DW-1:DW]
//   No storage exists behind the window. The Reg_flat slices for the window
//   indices always equal their INIT_VEC slices.
//
//   Optional feature: define REG_BANK_WLOCK_EN to enable the write lock.
//   Register LOCK_IDX bit0 is the lock. While the lock is set, storage writes
//   to any index other than LOCK_IDX are dropped and wlerr (LOCK_IDX bit15)
//   sets. Writing LOCK_IDX with bit15=1 clears wlerr. This feature needs
//   DW >= 16.
//
// Ports
//   Clk_reg       in   register clock
//   Reset         in   asynchronous active-high reset
//   CSB           in   chip select, active low
//   WRB           in   0 = write, 1 = read
//   CA[AW]        in   byte address; register index = CA[AW-1:1]
//   CD_in[DW]     in   write data
//   CD_out[DW]    out  registered read data, held while CSB stays low
//   Ack           out  one-cycle access acknowledge
//   Reg_flat      out  all register values, register i at [i*DW +: DW]
//   Cnt_rd_addr   out  counter address to RMON
//   Cnt_rd_apply  out  counter read request
//   Cnt_rd_grant  in   RMON grant, one-cycle pulse
//   Cnt_rd_dout   in   counter value, valid together with the grant
// -----------------------------------------------------------------------------
module reg_bank_ctl #(
   parameter int                 DW       = 16,
   parameter int                 AW       = 8,
   parameter int                 NREG     = 35,
   parameter logic [NREG*DW-1:0] INIT_VEC = '0,
   parameter logic [NREG-1:0]    SC_MASK  = '0,
   parameter int                 WIN_IDX  = 30,
   parameter int                 CNT_AW   = 6,
   parameter int                 TMO      = 255,
   parameter int                 LOCK_IDX = 34
) (
   input  logic                 Clk_reg,
   input  logic                 Reset,
   input  logic                 CSB,
   input  logic                 WRB,
   input  logic [AW-1:0]        CA,
   input  logic [DW-1:0]        CD_in,
   output logic [DW-1:0]        CD_out,
   output logic                 Ack,
   output logic [NREG*DW-1:0]   Reg_flat,
   output logic [CNT_AW-1:0]    Cnt_rd_addr,
   output logic                 Cnt_rd_apply,
   input  logic                 Cnt_rd_grant,
   input  logic [2*DW-1:0]      Cnt_rd_dout
);

   localparam logic [31:0] IDX_CMD  = 32'(WIN_IDX);
   localparam logic [31:0] IDX_SLO  = 32'(WIN_IDX + 1);
   localparam logic [31:0] IDX_SHI  = 32'(WIN_IDX + 2);
   localparam logic [31:0] IDX_NREG = 32'(NREG);
   localparam logic [15:0] TMO_LAST = 16'(TMO - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_DONE
   } cnt_state_e;

   function automatic logic is_win(input logic [31:0] ix);
      return (ix >= IDX_CMD) && (ix <= IDX_SHI);
   endfunction

   // ---------------------------------------------------------------------------
   // Access qualification
   // ---------------------------------------------------------------------------
   logic          cs_d;
   logic          start;
   logic          wr_stb;
   logic          rd_stb;
   logic [AW-2:0] ca_idx;
   logic [31:0]   idx_u;
   logic          cmd_wr;
   logic          stat_rd;
   logic          store_wr;
   logic          unused_ca0;

   assign ca_idx     = CA[AW-1:1];
   assign idx_u      = 32'(ca_idx);
   assign unused_ca0 = CA[0];

   // A start needs CSB to have been high at the previous edge. Holding CSB low
   // therefore commits exactly once.
   assign start   = !CSB && cs_d;
   assign wr_stb  = start && !WRB;
   assign rd_stb  = start &&  WRB;
   assign cmd_wr  = wr_stb && (idx_u == IDX_CMD);
   assign stat_rd = rd_stb && (idx_u == IDX_CMD);

   // NOTE: sequential state is updated only with non-blocking assignments, so
   // every flop samples its pre-edge inputs no matter how the blocks are
   // ordered.
   always_ff @(posedge Clk_reg or posedge Reset) begin
      if (Reset) begin
         cs_d <= 1'b1;
         Ack  <= 1'b0;
      end else begin
         cs_d <= CSB;
         Ack  <= start;
      end
   end

   // ---------------------------------------------------------------------------
   // Optional write lock
   // ---------------------------------------------------------------------------
   logic [DW-1:0] reg_q [NREG];

`ifdef REG_BANK_WLOCK_EN
   logic          lock_on;
   logic          wlerr_set;
   logic [DW-1:0] lock_wr_val;

   assign lock_on  = reg_q[LOCK_IDX][0];
   // While locked, only LOCK_IDX itself and the window stay writable.
   assign store_wr = wr_stb && !lock_on;
   assign wlerr_set = wr_stb && lock_on && (idx_u < IDX_NREG) && !is_win(idx_u)
                      && (idx_u != 32'(LOCK_IDX));

   // Writing bit15=1 clears wlerr. Writing bit15=0 leaves wlerr as it was.
   always_comb begin
      lock_wr_val     = CD_in;
      lock_wr_val[15] = CD_in[15] ? 1'b0 : reg_q[LOCK_IDX][15];
   end
`else
   assign store_wr = wr_stb;
`endif

   // ---------------------------------------------------------------------------
   // Register storage
   // ---------------------------------------------------------------------------
   // NOTE: every storage register is reset to its INIT_VEC slice. This is a
   // control register file, not a RAM, so software relies on known values
   // straight out of reset.
   always_ff @(posedge Clk_reg or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < NREG; i++) begin
            reg_q[i] <= INIT_VEC[i*DW +: DW];
         end
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (is_win(32'(i))) begin
               // Window indices have no storage and stay at their INIT value.
               reg_q[i] <= INIT_VEC[i*DW +: DW];
            end
`ifdef REG_BANK_WLOCK_EN
            else if (i == LOCK_IDX) begin
               if (wr_stb && (idx_u == 32'(i))) begin
                  reg_q[i] <= lock_wr_val;
               end else if (wlerr_set) begin
                  reg_q[i][15] <= 1'b1;
               end else if (SC_MASK[i]) begin
                  reg_q[i] <= INIT_VEC[i*DW +: DW];
               end
            end
`endif
            else if (store_wr && (idx_u == 32'(i))) begin
               reg_q[i] <= CD_in;
            end else if (SC_MASK[i]) begin
               // A self-clearing register shows a written value for one cycle.
               reg_q[i] <= INIT_VEC[i*DW +: DW];
            end
         end
      end
   end

   for (genvar g = 0; g < NREG; g++) begin : g_flat
      assign Reg_flat[g*DW +: DW] = reg_q[g];
   end

   // ---------------------------------------------------------------------------
   // Counter read engine
   // ---------------------------------------------------------------------------
   cnt_state_e       state_q, state_d;
   logic [15:0]      timer_q;
   logic [2*DW-1:0]  shadow_q;
   logic             busy_q, done_q, tmo_q, ovr_q;
   logic             accept_cmd, grant_ok, timeout, ovr_set;
   logic [DW-1:0]    status;

   assign status       = {{(DW-4){1'b0}}, ovr_q, tmo_q, done_q, busy_q};
   assign Cnt_rd_apply = (state_q == ST_REQ);

   always_ff @(posedge Clk_reg or posedge Reset) begin
      if (Reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // NOTE: every signal driven by a combinational block gets its default value
   // first, so no path through the case can leave one unassigned and infer a
   // latch.
   always_comb begin
      state_d    = state_q;
      accept_cmd = 1'b0;
      grant_ok   = 1'b0;
      timeout    = 1'b0;
      ovr_set    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_wr) begin
               accept_cmd = 1'b1;
               state_d    = ST_REQ;
            end
         end
         ST_REQ: begin
            if (cmd_wr) ovr_set = 1'b1;
            // The grant takes priority, so a grant in the cycle that would time
            // out still counts as success.
            if (Cnt_rd_grant) begin
               grant_ok = 1'b1;
               state_d  = ST_DONE;
            end else if (timer_q == TMO_LAST) begin
               timeout = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            // busy is already clear here, so a new command is accepted.
            if (cmd_wr) begin
               accept_cmd = 1'b1;
               state_d    = ST_REQ;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk_reg or posedge Reset) begin
      if (Reset) begin
         Cnt_rd_addr <= '0;
         timer_q     <= '0;
         shadow_q    <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         tmo_q       <= 1'b0;
         ovr_q       <= 1'b0;
      end else begin
         if (accept_cmd) begin
            Cnt_rd_addr <= CD_in[CNT_AW-1:0];
            timer_q     <= '0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            tmo_q       <= 1'b0;
         end else if (state_q == ST_REQ) begin
            timer_q <= timer_q + 16'd1;
         end
         if (grant_ok) begin
            shadow_q <= Cnt_rd_dout;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
         end
         if (timeout) begin
            busy_q <= 1'b0;
            tmo_q  <= 1'b1;
         end
         // A status read clears ovr on the same edge that CD_out captures it.
         if (ovr_set)      ovr_q <= 1'b1;
         else if (stat_rd) ovr_q <= 1'b0;
      end
   end

   // ---------------------------------------------------------------------------
   // Read path
   // ---------------------------------------------------------------------------
   logic [DW-1:0] rd_val;

   always_comb begin
      rd_val = '0;
      if (idx_u == IDX_CMD) begin
         rd_val = status;
      end else if (idx_u == IDX_SLO) begin
         rd_val = shadow_q[DW-1:0];
      end else if (idx_u == IDX_SHI) begin
         rd_val = shadow_q[2*DW-1:DW];
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (idx_u == 32'(i)) rd_val = reg_q[i];
         end
      end
   end

   // Read data stays on CD_out until the bus releases CSB.
   always_ff @(posedge Clk_reg or posedge Reset) begin
      if (Reset)       CD_out <= '0;
      else if (CSB)    CD_out <= '0;
      else if (rd_stb) CD_out <= rd_val;
   end

endmodule

// File: tb/tb_reg_bank_ctl.sv
module tb_reg_bank_ctl;
   localparam int DW   = 16;
   localparam int AW   = 8;
   localparam int NREG = 35;
   localparam logic [NREG*DW-1:0] INIT =
      ((NREG*DW)'(16'd1530) << (26*DW)) | (NREG*DW)'(16'd60);
   localparam logic [NREG-1:0] SCM = NREG'(1) << 10;

   localparam logic [7:0] CA_CMD = 8'h3C;   // index 30
   localparam logic [7:0] CA_SLO = 8'h3E;   // index 31
   localparam logic [7:0] CA_SHI = 8'h40;   // index 32

   logic             Clk_reg = 1'b0;
   logic             Reset;
   logic             CSB, WRB;
   logic [AW-1:0]    CA;
   logic [DW-1:0]    CD_in;
   logic [DW-1:0]    CD_out;
   logic             Ack;
   logic [NREG*DW-1:0] Reg_flat;
   logic [5:0]       Cnt_rd_addr;
   logic             Cnt_rd_apply;
   logic             Cnt_rd_grant;
   logic [2*DW-1:0]  Cnt_rd_dout;

   int checks    = 0;
   int failures  = 0;
   int ack_count = 0;

   logic [16:0] exp_q [$];   // {is_read, expected CD_out}
   string       name_q [$];

   always #5 Clk_reg = ~Clk_reg;

   reg_bank_ctl #(
      .DW(DW), .AW(AW), .NREG(NREG), .INIT_VEC(INIT), .SC_MASK(SCM),
      .WIN_IDX(30), .CNT_AW(6), .TMO(8), .LOCK_IDX(34)
   ) dut (
      .Clk_reg(Clk_reg), .Reset(Reset), .CSB(CSB), .WRB(WRB), .CA(CA),
      .CD_in(CD_in), .CD_out(CD_out), .Ack(Ack), .Reg_flat(Reg_flat),
      .Cnt_rd_addr(Cnt_rd_addr), .Cnt_rd_apply(Cnt_rd_apply),
      .Cnt_rd_grant(Cnt_rd_grant), .Cnt_rd_dout(Cnt_rd_dout)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] slice(input int i);
      return Reg_flat[i*DW +: DW];
   endfunction

   // One bus access, starting at a falling edge. CSB stays low for 'hold' cycles.
   task automatic bus(input logic wrb, input logic [7:0] addr, input logic [15:0] data,
                      input int hold, input logic [15:0] exp, input string name);
      CSB = 1'b0; WRB = wrb; CA = addr; CD_in = data;
      exp_q.push_back({wrb, exp});
      name_q.push_back(name);
      repeat (hold) @(negedge Clk_reg);
      if (wrb && hold > 1) check({name, "_held"}, 32'(CD_out), 32'(exp));
      CSB = 1'b1; WRB = 1'b1;
      @(negedge Clk_reg);
      if (wrb) check({name, "_released"}, 32'(CD_out), 32'h0);
   endtask

   task automatic wait_apply_low(input string name);
      int n = 0;
      while (Cnt_rd_apply && n < 40) begin
         @(negedge Clk_reg);
         n++;
      end
      check(name, 32'(Cnt_rd_apply), 32'h0);
   endtask

   // Monitor: each Ack pops one expectation from the scoreboard.
   initial begin : monitor
      logic        prev_ack;
      logic [16:0] e;
      string       n;
      prev_ack = 1'b0;
      forever begin
         @(negedge Clk_reg);
         if (Ack) begin
            ack_count++;
            check("ack_single_cycle", 32'(prev_ack), 32'h0);
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_ack: got ack with empty scoreboard, expected none");
            end else begin
               e = exp_q.pop_front();
               n = name_q.pop_front();
               if (e[16]) check(n, 32'(CD_out), 32'(e[15:0]));
            end
         end
         prev_ack = Ack;
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "time limit");
   end

   initial begin : stim
      int a0;
      int cnt;
      Reset = 1'b1; CSB = 1'b1; WRB = 1'b1; CA = '0; CD_in = '0;
      Cnt_rd_grant = 1'b0; Cnt_rd_dout = '0;
      @(negedge Clk_reg);
      // Reset state
      check("rst_slice0",  32'(slice(0)),  32'd60);
      check("rst_slice26", 32'(slice(26)), 32'd1530);
      check("rst_slice4",  32'(slice(4)),  32'd0);
      check("rst_cd_out",  32'(CD_out),    32'd0);
      check("rst_apply",   32'(Cnt_rd_apply), 32'd0);
      check("rst_ack",     32'(Ack),       32'd0);
      Reset = 1'b0;

      // A write with CSB held low for 5 cycles commits once and acks once.
      a0 = ack_count;
      bus(1'b0, 8'h08, 16'h0012, 5, 16'h0, "wr_idx4");
      check("wr_idx4_ack_count", 32'(ack_count - a0), 32'd1);
      check("wr_idx4_slice", 32'(slice(4)), 32'h0012);
      bus(1'b1, 8'h08, 16'h0, 3, 16'h0012, "rd_idx4");
      bus(1'b1, 8'h00, 16'h0, 1, 16'd60,   "rd_idx0_init");
      bus(1'b1, 8'h34, 16'h0, 1, 16'd1530, "rd_idx26_init");
      bus(1'b0, 8'h50, 16'hABCD, 1, 16'h0, "wr_idx40_unmapped");
      bus(1'b1, 8'h50, 16'h0, 1, 16'h0,    "rd_idx40_unmapped");
      bus(1'b1, 8'hFE, 16'h0, 1, 16'h0,    "rd_idx127_unmapped");

      // Self-clearing register 10 with CSB held low.
      CSB = 1'b0; WRB = 1'b0; CA = 8'h14; CD_in = 16'h0001;
      exp_q.push_back(17'h0); name_q.push_back("wr_sc10");
      @(negedge Clk_reg);
      check("sc10_first_cycle", 32'(slice(10)), 32'h1);
      @(negedge Clk_reg);
      check("sc10_cleared", 32'(slice(10)), 32'h0);
      @(negedge Clk_reg);
      check("sc10_no_rewrite", 32'(slice(10)), 32'h0);
      CSB = 1'b1; WRB = 1'b1;
      @(negedge Clk_reg);

      // Counter read with a grant.
      bus(1'b0, CA_CMD, 16'd5, 1, 16'h0, "cmd_addr5");
      check("cmd5_apply", 32'(Cnt_rd_apply), 32'h1);
      check("cmd5_addr",  32'(Cnt_rd_addr),  32'd5);
      bus(1'b1, CA_CMD, 16'h0, 1, 16'h0001, "stat_busy");
      Cnt_rd_grant = 1'b1; Cnt_rd_dout = 32'hDEAD_BEEF;
      @(negedge Clk_reg);
      Cnt_rd_grant = 1'b0; Cnt_rd_dout = '0;
      check("grant_apply_drop", 32'(Cnt_rd_apply), 32'h0);
      bus(1'b1, CA_CMD, 16'h0, 1, 16'h0002, "stat_done");
      bus(1'b1, CA_SLO, 16'h0, 1, 16'hBEEF, "shadow_lo");
      bus(1'b1, CA_SHI, 16'h0, 1, 16'hDEAD, "shadow_hi");
      // A grant while idle and a write to the shadow window are both ignored.
      Cnt_rd_grant = 1'b1; Cnt_rd_dout = 32'h0BAD_0BAD;
      @(negedge Clk_reg);
      Cnt_rd_grant = 1'b0; Cnt_rd_dout = '0;
      bus(1'b0, CA_SLO, 16'hFFFF, 1, 16'h0, "wr_shadow_ignored");
      bus(1'b1, CA_SLO, 16'h0, 1, 16'hBEEF, "shadow_lo_kept");
      check("win_slice31_init", 32'(slice(31)), 32'h0);

      // Timeout: apply stays high exactly TMO=8 cycles.
      CSB = 1'b0; WRB = 1'b0; CA = CA_CMD; CD_in = 16'd9;
      exp_q.push_back(17'h0); name_q.push_back("cmd_addr9");
      cnt = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge Clk_reg);
         CSB = 1'b1; WRB = 1'b1;
         if (Cnt_rd_apply) cnt++;
         else break;
      end
      check("tmo_apply_cycles", 32'(cnt), 32'd8);
      bus(1'b1, CA_CMD, 16'h0, 1, 16'h0004, "stat_tmo");
      bus(1'b1, CA_SLO, 16'h0, 1, 16'hBEEF, "tmo_shadow_lo");
      bus(1'b1, CA_SHI, 16'h0, 1, 16'hDEAD, "tmo_shadow_hi");

      // A command while busy sets ovr. A status read clears it.
      bus(1'b0, CA_CMD, 16'd3, 1, 16'h0, "cmd_addr3");
      bus(1'b0, CA_CMD, 16'd7, 1, 16'h0, "cmd_addr7_busy");
      check("ovr_addr_kept", 32'(Cnt_rd_addr), 32'd3);
      bus(1'b1, CA_CMD, 16'h0, 1, 16'h0009, "stat_ovr");
      bus(1'b1, CA_CMD, 16'h0, 1, 16'h0001, "stat_ovr_cleared");
      wait_apply_low("ovr_case_apply_drop");
      bus(1'b1, CA_CMD, 16'h0, 1, 16'h0004, "stat_after_ovr");

      // A grant in the timeout cycle counts as success. A status read in that
      // same cycle returns the value from before the update.
      CSB = 1'b0; WRB = 1'b0; CA = CA_CMD; CD_in = 16'd12;
      exp_q.push_back(17'h0); name_q.push_back("cmd_addr12");
      @(negedge Clk_reg);
      CSB = 1'b1; WRB = 1'b1;
      repeat (7) @(negedge Clk_reg);
      Cnt_rd_grant = 1'b1; Cnt_rd_dout = 32'h1234_5678;
      CSB = 1'b0; WRB = 1'b1; CA = CA_CMD;
      exp_q.push_back({1'b1, 16'h0001}); name_q.push_back("stat_same_cycle");
      @(negedge Clk_reg);
      Cnt_rd_grant = 1'b0; Cnt_rd_dout = '0; CSB = 1'b1;
      check("edge_apply_drop", 32'(Cnt_rd_apply), 32'h0);
      @(negedge Clk_reg);
      bus(1'b1, CA_CMD, 16'h0, 1, 16'h0002, "edge_stat_done");
      bus(1'b1, CA_SLO, 16'h0, 1, 16'h5678, "edge_shadow_lo");
      bus(1'b1, CA_SHI, 16'h0, 1, 16'h1234, "edge_shadow_hi");

`ifdef REG_BANK_WLOCK_EN
      bus(1'b0, 8'h44, 16'h0001, 1, 16'h0, "lock_set");
      bus(1'b0, 8'h00, 16'h1111, 1, 16'h0, "locked_wr0");
      check("locked_slice0", 32'(slice(0)), 32'd60);
      check("wlerr_set", 32'(slice(34)), 32'h8001);
      bus(1'b0, 8'h44, 16'h8001, 1, 16'h0, "wlerr_clear");
      check("wlerr_cleared", 32'(slice(34)), 32'h0001);
      bus(1'b0, 8'h44, 16'h0000, 1, 16'h0, "unlock");
      bus(1'b0, 8'h00, 16'h1111, 1, 16'h0, "unlocked_wr0");
      check("unlocked_slice0", 32'(slice(0)), 32'h1111);
`endif

      // Reset in REQ drops apply without waiting for a clock edge.
      bus(1'b0, CA_CMD, 16'd2, 1, 16'h0, "cmd_addr2");
      check("pre_reset_apply", 32'(Cnt_rd_apply), 32'h1);
      #2 Reset = 1'b1;
      #1;
      check("async_reset_apply", 32'(Cnt_rd_apply), 32'h0);
      check("async_reset_slice4", 32'(slice(4)), 32'h0);
      check("async_reset_addr", 32'(Cnt_rd_addr), 32'h0);
      @(negedge Clk_reg);
      Reset = 1'b0;
      @(negedge Clk_reg);
      bus(1'b1, CA_CMD, 16'h0, 1, 16'h0000, "stat_after_reset");

      repeat (3) @(negedge Clk_reg);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
